// File: rtl/biriscv_csr_hpm_pkg.sv
// -----------------------------------------------------------------------------
// biriscv_csr_hpm_pkg
// Shared definitions for the counter / performance-monitor CSR bank:
//   - CSR addresses of the counter, shadow, enable, inhibit and event registers
//   - slot indices inside the 32-entry counter map
//   - bit positions of the mhpmevent fields (SEL, OVF_EN, OF)
// -----------------------------------------------------------------------------
package biriscv_csr_hpm_pkg;

    // Counter address map: low halves at 0xB00+N, high halves at 0xB80+N
    localparam logic [11:0] CSR_MCYCLE         = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET       = 12'hB02;
    localparam logic [11:0] CSR_MHPMCOUNTER3   = 12'hB03;
    localparam logic [11:0] CSR_HI_OFFSET      = 12'h080;
    localparam logic [11:0] CSR_USER_BASE      = 12'hC00;
    localparam logic [11:0] CSR_MCOUNTEREN     = 12'h306;
    localparam logic [11:0] CSR_MCOUNTINHIBIT  = 12'h320;
    localparam logic [11:0] CSR_MHPMEVENT3     = 12'h323;

    // Address pages used by the decoders
    localparam logic [3:0]  CSR_MCNT_PAGE      = 4'hB;
    localparam logic [3:0]  CSR_UCNT_PAGE      = 4'hC;
    localparam int          CSR_HI_BIT         = 7;

    // Slot indices inside the counter map (slot 1 is the unimplemented time)
    localparam logic [4:0]  IDX_CYCLE          = 5'd0;
    localparam logic [4:0]  IDX_INSTRET        = 5'd2;
    localparam logic [4:0]  IDX_HPM_FIRST      = 5'd3;

    // mhpmevent field positions
    localparam int          EVT_SEL_LSB        = 0;
    localparam int          EVT_SEL_MSB        = 7;
    localparam int          EVT_OVF_EN_BIT     = 30;
    localparam int          EVT_OF_BIT         = 31;

endpackage

// File: rtl/biriscv_hpm_counter.sv
// -----------------------------------------------------------------------------
// biriscv_hpm_counter
// One CNT_W-bit counter with 32-bit half-write ports. A half write in the same
// cycle as an increment takes priority and suppresses that increment.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   inc_i           increment enable for this cycle
//   amount_i        increment amount (0..2)
//   wr_lo_i/wr_hi_i write bits [31:0] / bits [CNT_W-1:32] from wdata_i
//   wdata_i         write data
//   count_o         current counter value
//   wrap_o          this cycle's increment carries out of CNT_W bits
// -----------------------------------------------------------------------------
module biriscv_hpm_counter #(
    parameter int CNT_W = 64
)(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic [1:0]       amount_i,
    input  logic             wr_lo_i,
    input  logic             wr_hi_i,
    input  logic [31:0]      wdata_i,
    output logic [CNT_W-1:0] count_o,
    output logic             wrap_o
);

    localparam int SUM_W = CNT_W + 1;
    localparam int HI_W  = CNT_W - 32;

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic [SUM_W-1:0] sum_s;
    logic             wrap_s;
    logic             unused_s;

    // Write bits above the implemented width are simply dropped
    assign unused_s = ^wdata_i;

    // Carry out of the top bit marks a wrap (max + 2 lands on 1)
    assign sum_s = {1'b0, cnt_r} + SUM_W'(amount_i);

    // Next-state selection: half write wins over increment
    always_comb begin
        cnt_next_s = cnt_r;
        wrap_s     = 1'b0;
        if (wr_lo_i) begin
            cnt_next_s[31:0] = wdata_i;
        end else if (wr_hi_i) begin
            cnt_next_s[CNT_W-1:32] = wdata_i[HI_W-1:0];
        end else if (inc_i) begin
            cnt_next_s = sum_s[CNT_W-1:0];
            wrap_s     = sum_s[CNT_W];
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Counter state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_next_s;
        end
    end

    assign count_o = cnt_r;
    assign wrap_o  = wrap_s;

endmodule

// File: rtl/biriscv_csr_hpm.sv
// -----------------------------------------------------------------------------
// biriscv_csr_hpm
// Counter / performance-monitor CSR bank: mcycle, minstret and NUM_HPM
// programmable mhpmcounters with event select, inhibit, mcounteren gating of
// user shadow reads and an overflow interrupt.
// Ports:
//   clk_i, rst_ni                     clock, asynchronous active-low reset
//   csr_ren_i, csr_raddr_i, priv_i    read request from issue stage
//   csr_rdata_o, csr_rhit_o,
//   csr_fault_o                       registered read response (E1)
//   csr_wen_i, csr_waddr_i,
//   csr_wdata_i                       write from writeback
//   retire_i                          instructions retired this cycle
//   events_i                          per-cycle event pulses
//   hpm_irq_o                         registered OR of all OF bits
// -----------------------------------------------------------------------------
module biriscv_csr_hpm
    import biriscv_csr_hpm_pkg::*;
#(
    parameter int NUM_HPM       = 4,
    parameter int CNT_W         = 64,
    parameter int NUM_EVT       = 16,
    parameter int SUPPORT_SUPER = 1
)(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               csr_ren_i,
    input  logic [11:0]        csr_raddr_i,
    input  logic [1:0]         priv_i,
    output logic [31:0]        csr_rdata_o,
    output logic               csr_rhit_o,
    output logic               csr_fault_o,
    input  logic               csr_wen_i,
    input  logic [11:0]        csr_waddr_i,
    input  logic [31:0]        csr_wdata_i,
    input  logic [1:0]         retire_i,
    input  logic [NUM_EVT-1:0] events_i,
    output logic               hpm_irq_o
);

    // Slots 0..NCNT-1 of the counter map; slot 1 (time) is never implemented
    localparam int          NCNT       = 3 + NUM_HPM;
    localparam logic [5:0]  NCNT_V     = 6'(NCNT);
    localparam logic [8:0]  NUM_EVT_V  = 9'(NUM_EVT);
    localparam logic [63:0] MASK_FULL  = (64'd1 << NCNT) - 64'd1;
    // Bit 1 and bits beyond the last counter are hardwired to zero
    localparam logic [31:0] CNT_MASK   = MASK_FULL[31:0] & 32'hFFFF_FFFD;

    logic [CNT_W-1:0] cnt_s     [0:31];
    logic [31:0]      evt_val_s [0:31];
    logic [31:0]      of_s;
    logic [255:0]     evt_ext_s;

    logic [31:0] inhibit_r;
    logic [31:0] counteren_r;
    logic [31:0] rdata_r;
    logic        rhit_r;
    logic        fault_r;
    logic        irq_r;

    logic        w_cnt_s;
    logic        w_evt_blk_s;
    logic [4:0]  w_idx_s;
    logic        w_hi_s;
    logic [1:0]  ret_amt_s;

    logic [4:0]  r_idx_s;
    logic        r_slot_ok_s;
    logic        r_hpm_ok_s;
    logic [63:0] r_cnt64_s;
    logic [31:0] r_cnt_half_s;
    logic [31:0] rdata_s;
    logic        rhit_s;
    logic        fault_s;
    logic        unused_s;

    // Unused inhibit bits are masked to zero on write
    assign unused_s  = ^inhibit_r;

    // Zero-extended event vector so any 8-bit selector indexes in range
    assign evt_ext_s = {{(256-NUM_EVT){1'b0}}, events_i};

    // Write address decode
    assign w_idx_s     = csr_waddr_i[4:0];
    assign w_hi_s      = csr_waddr_i[CSR_HI_BIT];
    assign w_cnt_s     = csr_wen_i && (csr_waddr_i[11:8] == CSR_MCNT_PAGE)
                         && (csr_waddr_i[6:5] == 2'b00);
    assign w_evt_blk_s = csr_wen_i && (csr_waddr_i[11:5] == CSR_MCOUNTINHIBIT[11:5]);

    // Retire count of 3 is treated as 2
    always_comb begin
        case (retire_i)
            2'd3:    ret_amt_s = 2'd2;
            default: ret_amt_s = retire_i;
        endcase
    end

    // Counter slots and, for programmable slots, their event registers
    for (genvar g = 0; g < 32; g++) begin : g_slot
        if ((g == 0) || (g == 2)) begin : g_fixed
            logic inc_s;
            logic [1:0] amt_s;
            logic unused_wrap_s;

            if (g == 0) begin : g_cycle
                assign inc_s = !inhibit_r[g];
                assign amt_s = 2'd1;
            end else begin : g_instret
                assign inc_s = !inhibit_r[g] && (ret_amt_s != 2'd0);
                assign amt_s = ret_amt_s;
            end

            biriscv_hpm_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk_i    (clk_i),
                .rst_ni   (rst_ni),
                .inc_i    (inc_s),
                .amount_i (amt_s),
                .wr_lo_i  (w_cnt_s && (w_idx_s == 5'(g)) && !w_hi_s),
                .wr_hi_i  (w_cnt_s && (w_idx_s == 5'(g)) && w_hi_s),
                .wdata_i  (csr_wdata_i),
                .count_o  (cnt_s[g]),
                .wrap_o   (unused_wrap_s)
            );

            assign evt_val_s[g] = 32'd0;
            assign of_s[g]      = 1'b0;
        end else if ((g >= 3) && (g < NCNT)) begin : g_hpm
            logic [7:0] sel_r;
            logic       ovf_en_r;
            logic       of_r;
            logic       of_next_s;
            logic       evt_hit_s;
            logic       evt_wr_s;
            logic       wrap_s;

            assign evt_wr_s = w_evt_blk_s && (w_idx_s == 5'(g));

            // SEL of 0 or beyond the event width never counts
            always_comb begin
                if ((sel_r != 8'd0) && ({1'b0, sel_r} <= NUM_EVT_V)) begin
                    evt_hit_s = evt_ext_s[sel_r - 8'd1];
                end else begin
                    evt_hit_s = 1'b0;
                end
            end

            // Hardware overflow set beats a software clear in the same cycle
            always_comb begin
                if (evt_wr_s) begin
                    of_next_s = csr_wdata_i[EVT_OF_BIT] | (wrap_s && ovf_en_r);
                end else begin
                    of_next_s = of_r | (wrap_s && ovf_en_r);
                end
            end

            // Event select / overflow registers
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    sel_r    <= 8'd0;
                    ovf_en_r <= 1'b0;
                    of_r     <= 1'b0;
                end else begin
                    if (evt_wr_s) begin
                        sel_r    <= csr_wdata_i[EVT_SEL_MSB:EVT_SEL_LSB];
                        ovf_en_r <= csr_wdata_i[EVT_OVF_EN_BIT];
                    end else begin
                        sel_r    <= sel_r;
                        ovf_en_r <= ovf_en_r;
                    end
                    of_r <= of_next_s;
                end
            end

            biriscv_hpm_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk_i    (clk_i),
                .rst_ni   (rst_ni),
                .inc_i    (!inhibit_r[g] && evt_hit_s),
                .amount_i (2'd1),
                .wr_lo_i  (w_cnt_s && (w_idx_s == 5'(g)) && !w_hi_s),
                .wr_hi_i  (w_cnt_s && (w_idx_s == 5'(g)) && w_hi_s),
                .wdata_i  (csr_wdata_i),
                .count_o  (cnt_s[g]),
                .wrap_o   (wrap_s)
            );

            assign evt_val_s[g] = {of_r, ovf_en_r, 22'd0, sel_r};
            assign of_s[g]      = of_r;
        end else begin : g_none
            assign cnt_s[g]     = '0;
            assign evt_val_s[g] = 32'd0;
            assign of_s[g]      = 1'b0;
        end
    end

    // mcounteren / mcountinhibit registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inhibit_r   <= 32'd0;
            counteren_r <= 32'd0;
        end else begin
            if (w_evt_blk_s && (w_idx_s == 5'd0)) begin
                inhibit_r <= csr_wdata_i & CNT_MASK;
            end else begin
                inhibit_r <= inhibit_r;
            end
            if (csr_wen_i && (csr_waddr_i == CSR_MCOUNTEREN)) begin
                counteren_r <= csr_wdata_i & CNT_MASK;
            end else begin
                counteren_r <= counteren_r;
            end
        end
    end

    // Read address decode and half selection
    assign r_idx_s      = csr_raddr_i[4:0];
    assign r_slot_ok_s  = (csr_raddr_i[6:5] == 2'b00)
                          && ((r_idx_s == IDX_CYCLE) || (r_idx_s == IDX_INSTRET)
                          || ((r_idx_s >= IDX_HPM_FIRST) && ({1'b0, r_idx_s} < NCNT_V)));
    assign r_hpm_ok_s   = (r_idx_s >= IDX_HPM_FIRST) && ({1'b0, r_idx_s} < NCNT_V);
    assign r_cnt64_s    = 64'(cnt_s[r_idx_s]);
    assign r_cnt_half_s = csr_raddr_i[CSR_HI_BIT] ? r_cnt64_s[63:32] : r_cnt64_s[31:0];

    // Read response: implemented-and-permitted, implemented-but-denied, or miss
    always_comb begin
        rdata_s = 32'd0;
        rhit_s  = 1'b0;
        fault_s = 1'b0;
        if (csr_ren_i) begin
            if ((csr_raddr_i[11:8] == CSR_MCNT_PAGE) && r_slot_ok_s) begin
                if (priv_i == 2'd3) begin
                    rhit_s  = 1'b1;
                    rdata_s = r_cnt_half_s;
                end else begin
                    fault_s = 1'b1;
                end
            end else if ((csr_raddr_i[11:8] == CSR_UCNT_PAGE) && r_slot_ok_s) begin
                if ((priv_i == 2'd3) || (SUPPORT_SUPER == 0) || counteren_r[r_idx_s]) begin
                    rhit_s  = 1'b1;
                    rdata_s = r_cnt_half_s;
                end else begin
                    fault_s = 1'b1;
                end
            end else if ((csr_raddr_i == CSR_MCOUNTEREN)
                         || (csr_raddr_i == CSR_MCOUNTINHIBIT)
                         || ((csr_raddr_i[11:5] == CSR_MCOUNTINHIBIT[11:5]) && r_hpm_ok_s)) begin
                if (priv_i != 2'd3) begin
                    fault_s = 1'b1;
                end else if (csr_raddr_i == CSR_MCOUNTEREN) begin
                    rhit_s  = 1'b1;
                    rdata_s = counteren_r;
                end else if (csr_raddr_i == CSR_MCOUNTINHIBIT) begin
                    rhit_s  = 1'b1;
                    rdata_s = inhibit_r;
                end else begin
                    rhit_s  = 1'b1;
                    rdata_s = evt_val_s[r_idx_s];
                end
            end else begin
                rhit_s  = 1'b0;
                fault_s = 1'b0;
            end
        end else begin
            rdata_s = 32'd0;
        end
    end

    // Registered read response and overflow interrupt
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_r <= 32'd0;
            rhit_r  <= 1'b0;
            fault_r <= 1'b0;
            irq_r   <= 1'b0;
        end else begin
            rdata_r <= rdata_s;
            rhit_r  <= rhit_s;
            fault_r <= fault_s;
            irq_r   <= |of_s;
        end
    end

    assign csr_rdata_o = rdata_r;
    assign csr_rhit_o  = rhit_r;
    assign csr_fault_o = fault_r;
    assign hpm_irq_o   = irq_r;

endmodule

// File: tb/tb_biriscv_csr_hpm.sv
// -----------------------------------------------------------------------------
// tb_biriscv_csr_hpm
// Directed bench for biriscv_csr_hpm. Two instances share all stimulus:
//   dut_a : default parameters (NUM_HPM=4, CNT_W=64)
//   dut_b : NUM_HPM=0, CNT_W=40
// -----------------------------------------------------------------------------
module tb_biriscv_csr_hpm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        csr_ren;
    logic [11:0] csr_raddr;
    logic [1:0]  priv;
    logic        csr_wen;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic [1:0]  retire;
    logic [15:0] events;

    logic [31:0] rdata_a, rdata_b;
    logic        rhit_a, rhit_b, fault_a, fault_b, irq_a, irq_b;

    int chk_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    biriscv_csr_hpm dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .csr_ren_i(csr_ren), .csr_raddr_i(csr_raddr), .priv_i(priv),
        .csr_rdata_o(rdata_a), .csr_rhit_o(rhit_a), .csr_fault_o(fault_a),
        .csr_wen_i(csr_wen), .csr_waddr_i(csr_waddr), .csr_wdata_i(csr_wdata),
        .retire_i(retire), .events_i(events), .hpm_irq_o(irq_a)
    );

    biriscv_csr_hpm #(.NUM_HPM(0), .CNT_W(40)) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .csr_ren_i(csr_ren), .csr_raddr_i(csr_raddr), .priv_i(priv),
        .csr_rdata_o(rdata_b), .csr_rhit_o(rhit_b), .csr_fault_o(fault_b),
        .csr_wen_i(csr_wen), .csr_waddr_i(csr_waddr), .csr_wdata_i(csr_wdata),
        .retire_i(retire), .events_i(events), .hpm_irq_o(irq_b)
    );

    // Single comparison point: counts every check, reports mismatches
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        csr_wen   = 1'b1;
        csr_waddr = a;
        csr_wdata = d;
        tick();
        csr_wen   = 1'b0;
    endtask

    task automatic csr_rd(input logic [11:0] a, input logic [1:0] p);
        csr_ren   = 1'b1;
        csr_raddr = a;
        priv      = p;
        tick();
        csr_ren   = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        csr_ren   = 1'b0;
        csr_raddr = 12'h000;
        priv      = 2'd3;
        csr_wen   = 1'b0;
        csr_waddr = 12'h000;
        csr_wdata = 32'h0000_0000;
        retire    = 2'd0;
        events    = 16'h0000;

        // Reset state
        tick();
        tick();
        check_val("rst_rdata", rdata_a, 32'h0000_0000);
        check_val("rst_rhit",  32'(rhit_a), 32'h0000_0000);
        check_val("rst_fault", 32'(fault_a), 32'h0000_0000);
        check_val("rst_irq",   32'(irq_a), 32'h0000_0000);
        rst_n = 1'b1;

        // Nine counted edges, then a read returns 9
        repeat (9) tick();
        csr_rd(12'hB00, 2'd3);
        check_val("mcycle9_a", rdata_a, 32'd9);
        check_val("mcycle9_hit", 32'(rhit_a), 32'd1);
        check_val("mcycle9_b", rdata_b, 32'd9);

        // No read request: response clears
        tick();
        check_val("idle_rdata", rdata_a, 32'h0000_0000);
        check_val("idle_rhit",  32'(rhit_a), 32'd0);

        csr_rd(12'h306, 2'd3);
        check_val("mcounteren_rst", rdata_a, 32'h0000_0000);

        // Inhibit masks, then minstret gating and retire=3 clamp
        csr_wr(12'h320, 32'hFFFF_FFFF);
        csr_rd(12'h320, 2'd3);
        check_val("inhibit_mask_a", rdata_a, 32'h0000_007D);
        check_val("inhibit_mask_b", rdata_b, 32'h0000_0005);
        csr_wr(12'h320, 32'h0000_0004);
        retire = 2'd2;
        repeat (5) tick();
        retire = 2'd0;
        csr_wr(12'h320, 32'h0000_0000);
        retire = 2'd2;
        repeat (3) tick();
        retire = 2'd0;
        csr_rd(12'hB02, 2'd3);
        check_val("minstret6", rdata_a, 32'd6);
        retire = 2'd3;
        tick();
        retire = 2'd0;
        csr_rd(12'hB02, 2'd3);
        check_val("minstret_ret3", rdata_a, 32'd8);
        csr_rd(12'hB82, 2'd3);
        check_val("minstret_hi", rdata_a, 32'd0);

        // hpm3 wrap with overflow enable, sticky OF and interrupt timing
        csr_wr(12'h323, 32'h4000_0005);
        csr_wr(12'hB03, 32'hFFFF_FFFF);
        csr_wr(12'hB83, 32'hFFFF_FFFF);
        events = 16'h0010;
        tick();
        events = 16'h0000;
        check_val("irq_not_yet", 32'(irq_a), 32'd0);
        tick();
        check_val("irq_set", 32'(irq_a), 32'd1);
        csr_rd(12'h323, 2'd3);
        check_val("evt3_of", rdata_a, 32'hC000_0005);
        csr_rd(12'hB03, 2'd3);
        check_val("hpm3_wrap_lo", rdata_a, 32'd0);
        csr_rd(12'hB83, 2'd3);
        check_val("hpm3_wrap_hi", rdata_a, 32'd0);
        csr_wr(12'h323, 32'h4000_0005);
        check_val("irq_still", 32'(irq_a), 32'd1);
        tick();
        check_val("irq_clr", 32'(irq_a), 32'd0);

        // Shadow writes ignored; SEL=0 and SEL>NUM_EVT never count
        csr_wr(12'hC03, 32'h0000_1234);
        csr_rd(12'hB03, 2'd3);
        check_val("shadow_wr_ign", rdata_a, 32'd0);
        csr_wr(12'h324, 32'h0000_0000);
        csr_wr(12'h325, 32'h0000_0011);
        csr_wr(12'h326, 32'h0000_0010);
        events = 16'hFFFF;
        repeat (3) tick();
        events = 16'h0000;
        csr_rd(12'hB03, 2'd3);
        check_val("hpm3_cnt", rdata_a, 32'd3);
        csr_rd(12'hB04, 2'd3);
        check_val("hpm4_sel0", rdata_a, 32'd0);
        csr_rd(12'hB05, 2'd3);
        check_val("hpm5_sel17", rdata_a, 32'd0);
        csr_rd(12'hB06, 2'd3);
        check_val("hpm6_sel16", rdata_a, 32'd3);
        csr_rd(12'h325, 2'd3);
        check_val("evt5_rd", rdata_a, 32'h0000_0011);

        // Write beats the same-cycle increment; other half kept
        csr_wr(12'hB80, 32'h0000_0005);
        csr_wr(12'hB00, 32'h0000_0100);
        csr_rd(12'hB00, 2'd3);
        check_val("mcycle_wr_lo", rdata_a, 32'h0000_0100);
        csr_rd(12'hB80, 2'd3);
        check_val("mcycle_wr_hi", rdata_a, 32'h0000_0005);

        // Privilege and mcounteren gating
        csr_rd(12'hC00, 2'd0);
        check_val("u_cyc_fault", 32'(fault_a), 32'd1);
        check_val("u_cyc_hit0",  32'(rhit_a), 32'd0);
        check_val("u_cyc_data0", rdata_a, 32'd0);
        csr_wr(12'h306, 32'h0000_0001);
        csr_rd(12'hC00, 2'd0);
        check_val("u_cyc_hit",   32'(rhit_a), 32'd1);
        check_val("u_cyc_nofault", 32'(fault_a), 32'd0);
        csr_rd(12'hC02, 2'd0);
        check_val("u_ins_fault", 32'(fault_a), 32'd1);
        csr_rd(12'hB00, 2'd0);
        check_val("u_mcyc_fault", 32'(fault_a), 32'd1);
        check_val("u_mcyc_data",  rdata_a, 32'd0);
        csr_rd(12'h306, 2'd3);
        check_val("mcounteren_rd", rdata_a, 32'h0000_0001);

        // Reduced configuration: missing hpm3, 40-bit counter width and wrap
        csr_rd(12'hB03, 2'd3);
        check_val("b_hpm3_hit",   32'(rhit_b), 32'd0);
        check_val("b_hpm3_fault", 32'(fault_b), 32'd0);
        check_val("a_hpm3_hit",   32'(rhit_a), 32'd1);
        csr_wr(12'hB80, 32'hFFFF_FFFF);
        csr_rd(12'hB80, 2'd3);
        check_val("b_hi_width", rdata_b, 32'h0000_00FF);
        csr_wr(12'hB00, 32'hFFFF_FFFF);
        csr_rd(12'hB00, 2'd3);
        check_val("b_max_lo", rdata_b, 32'hFFFF_FFFF);
        csr_rd(12'hB80, 2'd3);
        check_val("b_wrap_hi", rdata_b, 32'h0000_0000);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/biriscv_csr_hpm.md
Name: biriscv_csr_hpm

Overview:
Parametrised counter/performance-monitor CSR bank for the dual-issue core: mcycle, minstret and NUM_HPM programmable mhpmcounters with event select, inhibit, user-mode read gating and overflow interrupt. It sits beside the CSR register file. Reads are issued in the issue stage and return a registered result in E1; writes arrive from writeback. It generalises the previous fixed counter handling in counter count, counter width, event count and overflow mode.

Parameters:
NUM_HPM, 4, number of programmable counters mhpmcounter3..(3+NUM_HPM-1); legal 0..29
CNT_W, 64, implemented counter width; legal 33..64; bits above CNT_W read 0 and ignore writes
NUM_EVT, 16, width of events_i; legal 1..255
SUPPORT_SUPER, 1, 1 = apply mcounteren gating to non-machine reads; 0 = user counters always readable

Ports:
clk_i  in  1  core clock
rst_ni  in  1  asynchronous active-low reset
csr_ren_i  in  1  read request (issue stage)
csr_raddr_i  in  12  read address
priv_i  in  2  current privilege (0=U,1=S,3=M)
csr_rdata_o  out  32  registered read data (E1)
csr_rhit_o  out  1  registered: address implemented and access permitted
csr_fault_o  out  1  registered: address implemented but access denied by privilege or mcounteren
csr_wen_i  in  1  write strobe (writeback)
csr_waddr_i  in  12  write address
csr_wdata_i  in  32  write data, already merged for set/clear
retire_i  in  2  instructions retired this cycle (0..2; 3 treated as 2)
events_i  in  NUM_EVT  per-cycle event pulses
hpm_irq_o  out  1  registered counter-overflow interrupt

Behaviour:
- Reset (rst_ni low, asynchronous): all counters, mcountinhibit, mcounteren, mhpmevent, csr_rdata_o, csr_rhit_o, csr_fault_o and hpm_irq_o are 0.
- Map (low/high): mcycle 0xB00/0xB80, minstret 0xB02/0xB82, mhpmcounterN 0xB00+N/0xB80+N.
- User shadows (read-only): 0xC00+/0xC80+ with the same offsets.
- Other CSRs: mcounteren 0x306, mcountinhibit 0x320, mhpmeventN 0x320+N.
- Bit 1 of mcounteren and mcountinhibit is hardwired 0. Bits above 2+NUM_HPM are hardwired 0.
- mhpmeventN fields: [7:0] SEL, [30] OVF_EN, [31] OF. Other bits read 0.
- Counting, per cycle:
  - mcycle += 1 unless inhibit[0].
  - minstret += retire_i unless inhibit[2].
  - hpmN += 1 if !inhibit[N], 1<=SEL<=NUM_EVT and events_i[SEL-1]=1. SEL=0 or SEL>NUM_EVT never counts.
- Wrap: a counter at 2^CNT_W-1 that increments becomes 0. minstret at max with retire_i=2 becomes 1.
- On hpm wrap with OVF_EN=1, OF is set. OF is sticky until software writes it to 0.
- Write-vs-increment: a CSR write to a counter half in the same cycle as an increment wins. That counter takes the written half with the other half unchanged, and no increment is applied that cycle.
- A write to mhpmeventN that clears OF, in the same cycle as a new overflow, leaves OF=1 (hardware set wins).
- Writes to 0xC00-0xC9F and to unimplemented addresses are ignored.
- Read: one-cycle latency. The cycle after csr_ren_i, csr_rdata_o holds the value before that cycle's increment or write.
- When csr_ren_i=0, the next cycle csr_rdata_o, csr_rhit_o and csr_fault_o are 0.
- Read access rules:
  - 0xBxx/0x3xx addresses with priv_i<3 give fault=1, rhit=0, rdata=0.
  - 0xCxx addresses with priv_i<3, SUPPORT_SUPER=1 and mcounteren bit clear give fault=1.
  - Unimplemented addresses give rhit=0, fault=0.
- hpm_irq_o is registered: the OR of all OF bits, one cycle after OF changes.

Decomposition:
- Shared package/defs: CSR address constants (MCYCLE, MINSTRET, MHPMCOUNTER3 base, high-half offset 0x80, user shadow base 0xC00, MCOUNTEREN, MCOUNTINHIBIT, MHPMEVENT3 base) and mhpmevent field positions (SEL, OVF_EN, OF).
- One sub-module: biriscv_hpm_counter. It holds one CNT_W counter with inc/amount, half-write ports, wrap flag and write-wins priority. It is instantiated 2+NUM_HPM times via generate.

Test Plan:
- Reset release, then read 0xB00 at cycle 10 (priv 3) -> rdata=9 one cycle later (counter counted cycles 0..8 before the sample), rhit=1.
- Write mcountinhibit=0x4; drive retire_i=2 for 5 cycles; clear inhibit; drive retire_i=2 for 3 cycles -> minstret=6.
- Set mhpmevent3 SEL=5, OVF_EN=1; write mhpmcounter3 low=0xFFFFFFFF, high=0xFFFFFFFF (CNT_W=64); pulse events_i[4] -> counter=0, OF=1, hpm_irq_o=1 the next cycle; write OF=0 -> hpm_irq_o=0.
- Write mcycle low=0x100 in the same cycle as an increment -> the next read gives 0x100, not 0x101; high half unchanged.
- priv_i=0, mcounteren=0, read 0xC00 -> fault=1, rdata=0; set mcounteren=1, reread -> rhit=1. Read 0xB00 at priv 0 -> fault=1.
- NUM_HPM=0, CNT_W=40: read 0xB03 -> rhit=0, fault=0. Write 0xFFFFFFFF to 0xB80 -> reads back 0x000000FF.
